// File: rtl/test_dout_src.sv
//------------------------------------------------------------------------------
// Module   : test_dout_src
// Purpose  : Self-timed stimulus source emitting alternating counter / PRBS
//            bursts on a registered valid/data output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module test_dout_src #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              dout_valid,
    output logic [DWIDTH-1:0] dout_data
);

    localparam logic [2:0]  S_WAIT     = 3'd0;
    localparam logic [2:0]  S_INC      = 3'd1;
    localparam logic [2:0]  S_GAP_A    = 3'd2;
    localparam logic [2:0]  S_PRBS     = 3'd3;
    localparam logic [2:0]  S_GAP_B    = 3'd4;

    localparam logic [4:0]  BURST_LAST = 5'd15;
    localparam logic [4:0]  IDLE_LAST  = 5'd3;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    logic [2:0]        state_q, state_d;
    logic [4:0]        phase_q, phase_d;
    logic [DWIDTH-1:0] cnt_q,   cnt_d;
    logic [15:0]       lfsr_q,  lfsr_d;
    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] data_q,  data_d;

    logic [15:0]       lfsr_next;
    logic [DWIDTH-1:0] lfsr_beat;
    logic              phase_last;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // PRBS beats carry the LFSR resized to the data width
    generate
        if (DWIDTH > 16) begin : g_prbs_wide
            assign lfsr_beat = {{(DWIDTH-16){1'b0}}, lfsr_q};
        end else if (DWIDTH == 16) begin : g_prbs_exact
            assign lfsr_beat = lfsr_q;
        end else begin : g_prbs_narrow
            assign lfsr_beat = lfsr_q[DWIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_WAIT;
            phase_q <= 5'd0;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q + 5'd1;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        phase_last = (state_q == S_INC || state_q == S_PRBS) ?
                     (phase_q == BURST_LAST) : (phase_q == IDLE_LAST);

        if (state_q == S_INC)  cnt_d  = cnt_q + DWIDTH'(1);
        if (state_q == S_PRBS) lfsr_d = lfsr_next;

        if (phase_last) begin
            phase_d = 5'd0;
            case (state_q)
                S_WAIT:  state_d = S_INC;
                S_INC:   state_d = S_GAP_A;
                S_GAP_A: state_d = S_PRBS;
                S_PRBS:  state_d = S_GAP_B;
                S_GAP_B: state_d = S_INC;
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Idle states keep the last beat on the data bus
    always_comb begin
        valid_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            S_INC: begin
                valid_d = 1'b1;
                data_d  = cnt_q;
            end
            S_PRBS: begin
                valid_d = 1'b1;
                data_d  = lfsr_beat;
            end
            default: ;
        endcase
    end

    assign dout_valid = valid_q;
    assign dout_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_test_dout_src.sv
//------------------------------------------------------------------------------
// Module   : tb_test_dout_src
// Purpose  : Randomized reset-interruption bench for test_dout_src at DWIDTH
//            16 and 4 against an edge-indexed schedule model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_test_dout_src;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v16, v4;
    logic [15:0] d16;
    logic [3:0]  d4;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [15:0] lfsr_ref [0:511];

    test_dout_src #(.DWIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst),
        .dout_valid (v16),
        .dout_data  (d16)
    );

    test_dout_src #(.DWIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst),
        .dout_valid (v4),
        .dout_data  (d4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=0x%0h exp=0x%0h", tag, edge_n, got, exp);
        end
    endtask

    // Expected output registered at edge n after reset release (edge 1 = first)
    function automatic void expect_at(input int n, output logic v, output logic [31:0] d);
        int m, r, p;
        v = 1'b0;
        d = 0;
        if (n >= 5) begin
            m = n - 5;
            r = m / 40;
            p = m % 40;
            if (p < 16) begin
                v = 1'b1;
                d = r * 16 + p;
            end else if (p < 20) begin
                d = r * 16 + 15;
            end else if (p < 36) begin
                v = 1'b1;
                d = {16'h0, lfsr_ref[r * 16 + (p - 20)]};
            end else begin
                d = {16'h0, lfsr_ref[r * 16 + 15]};
            end
        end
    endfunction

    task automatic check_now();
        logic        v;
        logic [31:0] d;
        expect_at(edge_n, v, d);
        check("valid16", {31'h0, v16}, {31'h0, v});
        check("data16",  {16'h0, d16}, d & 32'hFFFF);
        check("valid4",  {31'h0, v4},  {31'h0, v});
        check("data4",   {28'h0, d4},  d & 32'hF);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid16"}, {31'h0, v16}, 32'h0);
        check({tag, "_data16"},  {16'h0, d16}, 32'h0);
        check({tag, "_valid4"},  {31'h0, v4},  32'h0);
        check({tag, "_data4"},   {28'h0, d4},  32'h0);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            check_now();
        end
    endtask

    // Asynchronous reset mid-cycle, held for a few edges, released on a negedge
    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int beats, run_len, run_max;
        lfsr_ref[0] = 16'hACE1;
        for (int i = 1; i < 512; i++)
            lfsr_ref[i] = lfsr_ref[i-1][0] ? ((lfsr_ref[i-1] >> 1) ^ 16'hB400)
                                           : (lfsr_ref[i-1] >> 1);

        #1;
        check_zero("por");
        repeat (3) begin
            @(negedge clk);
            check_zero("por_hold");
        end
        rst = 1'b0;

        // First long run: beat count over the 400 cycles following first valid
        beats   = 0;
        run_len = 0;
        run_max = 0;
        for (int i = 0; i < 440; i++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            check_now();
            if (edge_n >= 5 && edge_n <= 404 && v16) beats++;
            run_len = v16 ? run_len + 1 : 0;
            if (run_len > run_max) run_max = run_len;
        end
        check("beats_400", beats, 320);
        check("max_run", run_max, 16);

        // Reset during PRBS beat 7 (registered on edge 31)
        pulse_reset(2);
        run(30);
        pulse_reset(1);
        run(90);

        for (int k = 0; k < 8; k++) begin
            run($urandom_range(1, 130));
            pulse_reset($urandom_range(1, 3));
        end
        run(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_dout_src.md
# test_dout_src

Self-timed test-pattern source that needs no upstream input. After reset it produces a fixed, repeating schedule of bursts on a valid/data output. Bursts alternate between an incrementing counter and a 16-bit PRBS. It sits at the head of a datapath under test, or in a bench, as a deterministic stimulus generator. Every downstream consumer can predict each beat exactly.

## Interface
- DWIDTH, 16, width of dout_data (≥1)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-high (asserted = 1, despite the name)
- dout_valid  output  1  high when dout_data carries a beat; registered
- dout_data  output  DWIDTH  beat payload; registered

## Operation
- FSM states: WAIT, INC, GAP_A, PRBS, GAP_B.
- Internal state:
  - phase counter (5 bits)
  - sequence counter cnt (DWIDTH bits)
  - 16-bit Galois LFSR
- WAIT: 4 cycles, dout_valid=0. Entered only from reset.
- INC: 16 beats, dout_valid=1.
  - dout_data = cnt; cnt increments by 1 after each beat.
  - cnt wraps modulo 2^DWIDTH.
- GAP_A: 4 cycles, dout_valid=0; dout_data holds the last beat value.
- PRBS: 16 beats, dout_valid=1.
  - dout_data = LFSR value, zero-extended or truncated to the low DWIDTH bits.
  - LFSR advances after each beat.
- GAP_B: 4 cycles, dout_valid=0; dout_data holds.
- Then back to INC.
- Round period: 40 cycles. cnt and LFSR persist across rounds; they are not re-seeded.
- LFSR rules:
  - Seed 0xACE1 at reset.
  - Next state: if lsb=1, next = (s>>1) ^ 0xB400; else next = s>>1.
  - Sequence: ACE1, E270, 7138, 389C, …
  - It never reaches 0.
- No backpressure: the consumer must accept every valid beat. Dropped beats are not the block's concern.

## Timing
- While rst_n=1:
  - dout_valid=0 and dout_data=0 immediately (asynchronous).
  - State=WAIT, phase=0, cnt=0, LFSR=0xACE1.
- Edge numbering: edge 1 is the first rising clk edge with rst_n=0.
- Edges 1–4: WAIT, outputs remain 0.
- Edge 5: registers the first INC beat, so dout_valid=1 and dout_data=0 from edge 5 until edge 6.
- Edges 5–20: INC beats with data 0..15.
- Edges 21–24: GAP_A, valid=0, data=15.
- Edges 25–40: PRBS beats ACE1, E270, 7138, 389C, …
- Edges 41–44: GAP_B.
- Edge 45: INC beat data=16.
- Latency: each output changes only on a rising edge. No combinational path from any input to any output.
- Reset asserted mid-burst: outputs clear immediately and the whole schedule restarts from WAIT. cnt and LFSR are restored to 0 and 0xACE1.
- cnt wrap, e.g. DWIDTH=4: the INC burst sequence wraps 15→0 with no gap and no flag.
- DWIDTH<16: PRBS beats carry the low DWIDTH bits of the LFSR; the LFSR itself is always 16 bits.
- DWIDTH>16: the upper bits of PRBS beats are 0.

## Test plan
- Reset hold then release, DWIDTH=16 → valid=0 and data=0 through edge 4; first valid at edge 5 with data 0x0000.
- Full first round → 16 beats 0..15, then 4 idle cycles with data held at 15, then 16 PRBS beats starting ACE1, E270, 7138, 389C, then 4 idle cycles.
- Second round → INC beats 16..31; PRBS continues from the 17th LFSR value, not from ACE1.
- Reset pulse asserted during PRBS beat 7 → outputs go to 0 immediately, without waiting for clk; after release, the schedule repeats exactly as after the first reset.
- DWIDTH=4 → first PRBS beat = 0x1 (low nibble of ACE1); second round INC beats are 0..15 again because cnt wrapped.
- Beat count over 400 cycles after the first valid → exactly 320 valid beats; valid never high in more than 16 consecutive cycles.
